lfsr_rng: RTL and testbench

//  Parametrised Fibonacci LFSR random source for the game logic (tug-of-war AI

---
 rtl/game_pkg.sv | 29 ++
 rtl/lfsr_core.sv | 49 ++++
 rtl/lfsr_rng.sv | 99 +++++++++
 tb/tb_lfsr_rng.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game random source: FSM encoding, default LFSR
// constants and a constant-friendly clog2.
package game_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGather = 2'd1;
    localparam logic [1:0] StValid  = 2'd2;

    localparam logic [31:0] DefaultSeed = 32'h1;

    // Maximal-length feedback masks for a right-shifting Fibonacci LFSR.
    function automatic logic [31:0] default_taps(input int unsigned width);
        case (width)
            4:       return 32'h0000_0003;
            10:      return 32'h0000_0009;
            default: return 32'h0000_002D;
        endcase
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with seed register, zero-seed protection and a pulse when a
// step returns the state to the most recently loaded seed.
module lfsr_core import game_pkg::*; #(
    parameter int unsigned       WIDTH = 16,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(DefaultSeed)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             wrap
);

    logic [WIDTH-1:0] state_q, seed_q;
    logic [WIDTH-1:0] step_val, load_eff;
    logic             wrap_q;
    logic             fb;

    always_comb begin
        fb       = ^(state_q & TAPS);
        step_val = {fb, state_q[WIDTH-1:1]};
        // Zero would lock the register up, so fall back to the reset seed.
        load_eff = (load_val == '0) ? SEED : load_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
            seed_q  <= SEED;
            wrap_q  <= 1'b0;
        end else if (load) begin
            state_q <= load_eff;
            seed_q  <= load_eff;
            wrap_q  <= 1'b0;
        end else if (en) begin
            state_q <= step_val;
            wrap_q  <= (step_val == seed_q);
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign state = state_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/lfsr_rng.sv
// Game random source: free-running LFSR with a serial bit and a word assembler
// serving OUT_BITS-wide words over a req/valid/ack handshake.
module lfsr_rng import game_pkg::*; #(
    parameter int unsigned       WIDTH    = 16,
    parameter logic [WIDTH-1:0]  TAPS     = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0]  SEED     = WIDTH'(DefaultSeed),
    parameter int unsigned       OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                req,
    input  logic                rnd_ack,
    output logic                bit_out,
    output logic [OUT_BITS-1:0] rnd_data,
    output logic                rnd_valid,
    output logic                period_wrap
);

    localparam int unsigned CntW = clog2(OUT_BITS + 1);

    logic [WIDTH-1:0]    lfsr_state;
    logic [1:0]          fsm_q, fsm_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [OUT_BITS-1:0] data_q, data_d, data_shift;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_state),
        .wrap     (period_wrap)
    );

    assign bit_out = lfsr_state[WIDTH-1];

    generate
        if (OUT_BITS == 1) begin : g_shift_one
            assign data_shift = bit_out;
        end else begin : g_shift_many
            assign data_shift = {data_q[OUT_BITS-2:0], bit_out};
        end
    endgenerate

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (seed_load) begin
            // A reseed invalidates any word in flight.
            fsm_d = StIdle;
            cnt_d = '0;
        end else begin
            case (fsm_q)
                StIdle: begin
                    if (req) begin
                        fsm_d = StGather;
                        cnt_d = '0;
                    end
                end
                StGather: begin
                    if (en) begin
                        data_d = data_shift;
                        cnt_d  = cnt_q + CntW'(1);
                        if (cnt_q == CntW'(OUT_BITS - 1)) fsm_d = StValid;
                    end
                end
                StValid: begin
                    if (rnd_ack) fsm_d = StIdle;
                end
                default: fsm_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= StIdle;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign rnd_data  = data_q;
    assign rnd_valid = (fsm_q == StValid);

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed scenarios plus random traffic
// against a behavioural model, and a full-period check with default parameters.
module tb_lfsr_rng;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, seed_load = 1'b0, req = 1'b0, rnd_ack = 1'b0;
    logic [3:0] seed_in = 4'h0;
    logic       bit_out, rnd_valid, period_wrap;
    logic [3:0] rnd_data;

    logic        rst2_n = 1'b0;
    logic        en2 = 1'b1;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0;
    logic        bit_out2, rnd_valid2, period_wrap2;
    logic [7:0]  rnd_data2;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    int m_state, m_seed, m_mode, m_cnt, m_data, m_wrap;
    localparam int MIdle = 0, MGather = 1, MValid = 2;

    always #5 clk = ~clk;

    lfsr_rng #(
        .WIDTH    (4),
        .TAPS     (4'b0011),
        .SEED     (4'h1),
        .OUT_BITS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .req         (req),
        .rnd_ack     (rnd_ack),
        .bit_out     (bit_out),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .period_wrap (period_wrap)
    );

    lfsr_rng dut_def (
        .clk         (clk),
        .rst_n       (rst2_n),
        .en          (en2),
        .seed_load   (zero1),
        .seed_in     (zero16),
        .req         (zero1),
        .rnd_ack     (zero1),
        .bit_out     (bit_out2),
        .rnd_data    (rnd_data2),
        .rnd_valid   (rnd_valid2),
        .period_wrap (period_wrap2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 1; m_seed = 1; m_mode = MIdle; m_cnt = 0; m_data = 0; m_wrap = 0;
    endtask

    function automatic int lfsr_next(input int s);
        int fb;
        fb = $countones(s & 4'b0011) % 2;
        return (s >> 1) + fb * 8;
    endfunction

    task automatic model_step(input logic e, sl, input logic [3:0] si, input logic rq, ak);
        int b;
        b = m_state / 8;
        m_wrap = 0;
        if (sl) begin
            m_mode = MIdle; m_cnt = 0;
        end else if (m_mode == MIdle) begin
            if (rq) begin m_mode = MGather; m_cnt = 0; end
        end else if (m_mode == MGather) begin
            if (e) begin
                m_data = (m_data * 2 + b) % 16;
                m_cnt++;
                if (m_cnt == 4) m_mode = MValid;
            end
        end else if (ak) begin
            m_mode = MIdle;
        end
        if (sl) begin
            m_state = (si == 0) ? 1 : int'(si);
            m_seed  = m_state;
        end else if (e) begin
            m_state = lfsr_next(m_state);
            m_wrap  = (m_state == m_seed) ? 1 : 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 32'(dut.lfsr_state), 32'(m_state));
        check({tag, ".bit"},   32'(bit_out),        32'(m_state / 8));
        check({tag, ".valid"}, 32'(rnd_valid),      32'(m_mode == MValid));
        check({tag, ".data"},  32'(rnd_data),       32'(m_data));
        check({tag, ".wrap"},  32'(period_wrap),    32'(m_wrap));
    endtask

    // One clock: apply inputs, advance model, sample 1 time unit after the edge.
    task automatic cyc(input string tag, input logic e, sl, input logic [3:0] si,
                       input logic rq, ak);
        en = e; seed_load = sl; seed_in = si; req = rq; rnd_ack = ak;
        @(posedge clk);
        model_step(e, sl, si, rq, ak);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 0; seed_load = 0; seed_in = 0; req = 0; rnd_ack = 0;
        @(negedge clk);
        model_reset();
        compare_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_st [6];
        logic       exp_bit [6];
        int wraps, n;
        exp_st  = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6};
        exp_bit = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // 1: state sequence from reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc("t1", 1, 0, 0, 0, 0);
            check("t1.seq_state", 32'(dut.lfsr_state), 32'(exp_st[i]));
            check("t1.seq_bit",   32'(bit_out),        32'(exp_bit[i]));
        end

        // 2: period 15, never zero
        do_reset();
        wraps = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc("t2", 1, 0, 0, 0, 0);
            if (period_wrap) wraps++;
            check("t2.nonzero", 32'(dut.lfsr_state != 4'h0), 32'd1);
            check("t2.wrap_pos", 32'(period_wrap), 32'(i % 15 == 0));
        end
        check("t2.wrap_count", 32'(wraps), 32'd4);

        // 3: word assembly and hold
        cyc("t3.load", 0, 1, 4'h1, 0, 0);
        cyc("t3.req", 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t3.cap", 1, 0, 0, 0, 0);
        check("t3.valid", 32'(rnd_valid), 32'd1);
        check("t3.word", 32'(rnd_data), 32'h4);
        for (int i = 0; i < 10; i++) cyc("t3.hold", 1, 0, 0, 0, 0);
        check("t3.held", 32'(rnd_data), 32'h4);
        cyc("t3.ack", 1, 0, 0, 0, 1);
        check("t3.ack_valid", 32'(rnd_valid), 32'd0);

        // 4: zero seed fallback, load beats en
        cyc("t4.zero", 0, 1, 4'h0, 0, 0);
        check("t4.zero_state", 32'(dut.lfsr_state), 32'h1);
        cyc("t4.load_en", 1, 1, 4'h9, 0, 0);
        check("t4.no_step", 32'(dut.lfsr_state), 32'h9);
        check("t4.no_wrap", 32'(period_wrap), 32'd0);
        cyc("t4.step", 1, 0, 0, 0, 0);
        check("t4.stepC", 32'(dut.lfsr_state), 32'hC);

        // 5: abort, req in VALID, ack in IDLE
        cyc("t5.req", 0, 0, 0, 1, 0);
        cyc("t5.cap", 1, 0, 0, 0, 0);
        cyc("t5.cap", 1, 0, 0, 0, 0);
        cyc("t5.abort", 1, 1, 4'h3, 0, 0);
        for (int i = 0; i < 6; i++) cyc("t5.idle", 1, 0, 0, 0, 0);
        check("t5.abort_valid", 32'(rnd_valid), 32'd0);
        cyc("t5.ack_idle", 1, 0, 0, 0, 1);
        cyc("t5.req2", 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t5.cap2", 1, 0, 0, 0, 0);
        cyc("t5.req_valid", 1, 0, 0, 1, 0);
        check("t5.still_valid", 32'(rnd_valid), 32'd1);
        cyc("t5.req_ack", 1, 0, 0, 1, 1);
        cyc("t5.after", 1, 0, 0, 0, 0);
        check("t5.no_new_req", 32'(rnd_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom % 4) != 0, ($urandom % 16) == 0, 4'($urandom % 16),
                $urandom % 2 == 1, $urandom % 2 == 1);
        end

        // 6: asynchronous reset while a word is valid
        cyc("t6.load", 0, 1, 4'h1, 0, 0);
        cyc("t6.req", 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t6.cap", 1, 0, 0, 0, 0);
        check("t6.pre_valid", 32'(rnd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t6.async");
        @(negedge clk);
        rst_n = 1'b1;
        en = 0;

        // Default parameters: first wrap after 65535 steps
        @(negedge clk);
        rst2_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 70000; i++) begin
            @(posedge clk);
            #1;
            if (period_wrap2) begin
                n = i;
                break;
            end
        end
        check("t6.period_65535", 32'(n), 32'd65535);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
